muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It takes operands and an op code from that register's outputs, computes a 2·WIDTH-bit product or a quotient/remainder pair over WIDTH cycles, and writes the HI/LO result registers. While it computes, `busy` drives the pipeline stall logic, which holds the upstream pipeline registers.

---
 rtl/muldiv_unit_pkg.sv | 28 ++
 rtl/muldiv_unit_sign_fix.sv | 12 +
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 tb/tb_muldiv_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared CPU definitions for the iterative multiply/divide unit: op codes, FSM states,
// and the datapath width used by the pipeline registers.
package muldiv_unit_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {
        OpMult  = 2'b00,
        OpMultu = 2'b01,
        OpDiv   = 2'b10,
        OpDivu  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } state_e;

    function automatic logic is_signed_op(op_e op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

    function automatic logic is_div_op(op_e op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/muldiv_unit_sign_fix.sv
// Conditional two's-complement negate, used both to take magnitudes and to restore signs.
module muldiv_unit_sign_fix #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] val_i,
    input  logic             neg_i,
    output logic [Width-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + Width'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider producing HI/LO over Width cycles.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned Width = DefaultWidth
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [Width-1:0] src_a_i,
    input  logic [Width-1:0] src_b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] hi_o,
    output logic [Width-1:0] lo_o
);

    localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

    state_e             state_q;
    op_e                op_q;
    logic [CntW-1:0]    cnt_q;
    logic [Width-1:0]   a_q, b_q;
    logic [Width-1:0]   hi_q, lo_q;
    logic [2*Width-1:0] acc_q;

    logic [Width-1:0]   mag_a, mag_b;
    logic               neg_a, neg_b;
    logic [2*Width-1:0] acc_step;
    logic [2*Width-1:0] prod_fix;
    logic [Width-1:0]   quo_fix, rem_fix;
    logic [Width-1:0]   res_hi, res_lo;
    logic [CntW-1:0]    div_idx;
    logic [Width:0]     shifted;
    logic [Width:0]     mul_sum;
    logic               div_ge;

    assign neg_a = is_signed_op(op_q) & a_q[Width-1];
    assign neg_b = is_signed_op(op_q) & b_q[Width-1];

    muldiv_unit_sign_fix #(.Width(Width)) u_mag_a (
        .val_i (a_q),
        .neg_i (neg_a),
        .val_o (mag_a)
    );

    muldiv_unit_sign_fix #(.Width(Width)) u_mag_b (
        .val_i (b_q),
        .neg_i (neg_b),
        .val_o (mag_b)
    );

    // Multiply: acc high half accumulates, the product shifts down into the low half.
    // Divide: acc high half is the partial remainder, low half collects quotient bits.
    always_comb begin
        div_idx  = CntW'(Width - 1) - cnt_q;
        shifted  = {acc_q[2*Width-1:Width], mag_a[div_idx]};
        div_ge   = shifted >= {1'b0, mag_b};
        mul_sum  = {1'b0, acc_q[2*Width-1:Width]} + {1'b0, (mag_b[cnt_q] ? mag_a : '0)};
        acc_step = acc_q;
        if (is_div_op(op_q)) begin
            acc_step = {(div_ge ? Width'(shifted - {1'b0, mag_b}) : shifted[Width-1:0]),
                        acc_q[Width-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc_q[Width-1:1]};
        end
    end

    muldiv_unit_sign_fix #(.Width(2*Width)) u_fix_prod (
        .val_i (acc_step),
        .neg_i ((op_q == OpMult) && (neg_a ^ neg_b)),
        .val_o (prod_fix)
    );

    muldiv_unit_sign_fix #(.Width(Width)) u_fix_quo (
        .val_i (acc_step[Width-1:0]),
        .neg_i ((op_q == OpDiv) && (neg_a ^ neg_b)),
        .val_o (quo_fix)
    );

    muldiv_unit_sign_fix #(.Width(Width)) u_fix_rem (
        .val_i (acc_step[2*Width-1:Width]),
        .neg_i ((op_q == OpDiv) && neg_a),
        .val_o (rem_fix)
    );

    // The -2^(W-1) / -1 overflow case falls out of the magnitude path naturally.
    always_comb begin
        res_hi = prod_fix[2*Width-1:Width];
        res_lo = prod_fix[Width-1:0];
        if (is_div_op(op_q)) begin
            if (b_q == '0) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            op_q    <= OpMult;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        op_q    <= op_e'(op_i);
                        a_q     <= src_a_i;
                        b_q     <= src_b_i;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        state_q <= StCalc;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StCalc: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == CntW'(Width - 1)) begin
                            hi_q    <= res_hi;
                            lo_q    <= res_lo;
                            state_q <= StDone;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = (state_q == StCalc);
    assign done_o = (state_q == StDone);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: cycle-level behavioural model plus directed and randomized operations.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic          clk_i = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  src_a, src_b;
    logic          flush;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int checks = 0;
    int errors = 0;
    logic check_en = 1'b0;

    // Behavioural model state
    int            m_left = 0;
    logic          m_done = 1'b0;
    logic [W-1:0]  m_hi = '0, m_lo = '0;
    logic [63:0]   m_pend = '0;

    muldiv_unit #(.Width(W)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_n),
        .start_i (start),
        .op_i    (op),
        .src_a_i (src_a),
        .src_b_i (src_b),
        .flush_i (flush),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    initial forever #5 clk_i = ~clk_i;

    // Returns {hi, lo} straight from the arithmetic definition.
    function automatic logic [63:0] ref_op(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
        longint sp;
        int     q, r;
        case (o)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            2'b01: return 64'(a) * 64'(b);
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_i or negedge rst_n);
            if (!rst_n) begin
                m_left = 0;
                m_done = 1'b0;
                m_hi   = '0;
                m_lo   = '0;
            end else if (m_left > 0) begin
                m_done = 1'b0;
                if (flush) begin
                    m_left = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done = 1'b1;
                        {m_hi, m_lo} = m_pend;
                    end
                end
            end else begin
                m_done = 1'b0;
                if (start) begin
                    m_pend = ref_op(op, src_a, src_b);
                    m_left = W;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (check_en) begin
                check("busy", 64'(busy), 64'(m_left > 0));
                check("done", 64'(done), 64'(m_done));
                check("hi", 64'(hi), 64'(m_hi));
                check("lo", 64'(lo), 64'(m_lo));
            end
        end
    end

    // Issue one op; waits for done with a bound, checks latency and optional literals.
    task automatic run_op(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b,
                          logic lit, logic [W-1:0] ehi, logic [W-1:0] elo, string name);
        int waits;
        int busy_cnt;
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(negedge clk_i);
        start = 1'b0;
        src_a = $urandom; src_b = $urandom;
        waits = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && waits < 40) begin
            @(negedge clk_i);
            waits++;
            if (busy) busy_cnt++;
        end
        check({name, "_latency"}, 64'(waits), 64'(W + 1));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
        if (lit) begin
            check({name, "_hi"}, 64'(hi), 64'(ehi));
            check({name, "_lo"}, 64'(lo), 64'(elo));
        end
    endtask

    task automatic start_and_wait_calc(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b, int n);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(negedge clk_i);
        start = 1'b0;
        for (int i = 1; i < n; i++) @(negedge clk_i);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'(int'($urandom_range(0, 20)) - 10);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int waits;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_hilo", {hi, lo}, 64'h0);
        #2 rst_n = 1'b1;
        @(negedge clk_i);
        check_en = 1'b1;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        run_op(2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, "divu");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, "div_ovf");
        run_op(2'b11, 32'h1234, 32'h0, 1'b1, 32'h1234, 32'hFFFF_FFFF, "divu_zero");
        run_op(2'b10, 32'hFFFF_FF00, 32'h0, 1'b1, 32'hFFFF_FF00, 32'hFFFF_FFFF, "div_zero");

        // Flush mid-calc: results from the previous op must persist, no done pulse.
        run_op(2'b01, 32'd5, 32'd6, 1'b1, 32'd0, 32'd30, "multu_5x6");
        start_and_wait_calc(2'b11, 32'd9, 32'd3, 10);
        flush = 1'b1;
        @(negedge clk_i);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_hilo", {hi, lo}, {32'd0, 32'd30});
        repeat (40) begin
            @(negedge clk_i);
            check("flush_no_done", 64'(done), 64'(0));
        end

        // Asynchronous reset mid-calc clears outputs without a clock edge.
        start_and_wait_calc(2'b11, 32'd9, 32'd3, 5);
        #2 rst_n = 1'b0;
        #1;
        check("areset_busy", 64'(busy), 64'(0));
        check("areset_hilo", {hi, lo}, 64'h0);
        @(negedge clk_i);
        #2 rst_n = 1'b1;
        @(negedge clk_i);

        // Back-to-back: start held across the whole first op, operands changed mid-way.
        op = 2'b01; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
        @(negedge clk_i);
        src_a = 32'd4; src_b = 32'd5;
        waits = 1;
        while (!done && waits < 40) begin
            @(negedge clk_i);
            waits++;
        end
        check("b2b_first_lat", 64'(waits), 64'(W + 1));
        check("b2b_first_lo", 64'(lo), 64'd6);
        @(negedge clk_i);
        start = 1'b0;
        check("b2b_busy_again", 64'(busy), 64'(1));
        waits = 1;
        while (!done && waits < 40) begin
            @(negedge clk_i);
            waits++;
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1; src_a = $urandom; src_b = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_second_lat", 64'(waits), 64'(W + 1));
        check("b2b_second_lo", 64'(lo), 64'd20);
        @(negedge clk_i);

        // Randomized ops with ignored starts, occasional flushes and back-to-back starts.
        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            src_a = pick_operand();
            src_b = pick_operand();
            start = 1'b1;
            flush = 1'($urandom_range(0, 3) == 0);
            @(negedge clk_i);
            start = 1'b0;
            flush = 1'b0;
            waits = 0;
            while (busy && waits < 40) begin
                start = 1'($urandom_range(0, 7) == 0);
                src_a = $urandom; src_b = $urandom; op = 2'($urandom_range(0, 3));
                flush = 1'($urandom_range(0, 127) == 0);
                @(negedge clk_i);
                waits++;
            end
            start = 1'b0;
            flush = 1'b0;
            if (waits >= 40) check("rand_timeout", 64'(waits), 64'(W));
            if ($urandom_range(0, 1) == 0) @(negedge clk_i);
        end

        repeat (2) @(negedge clk_i);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
